// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types and constants for the pipeline hazard controller.
package hazard_pkg;
    typedef enum logic [1:0] {FWD_REG = 2'b00, FWD_WB = 2'b01, FWD_MEM = 2'b10} fwd_sel_t;
    typedef enum logic [1:0] {IDLE, BUSY, DONE} mul_state_t;
    localparam logic [3:0] PC_REG = 4'hF;
    // Memory-stage result is newer than writeback, so it wins; PC is never forwarded.
    function automatic fwd_sel_t fwdSel(input logic [3:0] ra, waM, waW, input logic wrM, wrW);
        return (ra == PC_REG) ? FWD_REG : (wrM && waM == ra) ? FWD_MEM : (wrW && waW == ra) ? FWD_WB : FWD_REG;
    endfunction
endpackage

// File: rtl/mc_sequencer.sv
// mc_sequencer: holds the Execute stage for the duration of a multi-cycle ALU op.
module mc_sequencer import hazard_pkg::*; #(
    parameter int MUL_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic kill,
    output logic busy,
    output logic done
);
    mul_state_t state;
    logic [4:0] cnt;
    logic accept;
    assign accept = !reset && state == IDLE && start && !kill;
    assign busy = accept || (!reset && state == BUSY);
    assign done = state == DONE;
    // cnt counts the BUSY cycles still to come; DONE follows the one where it reaches zero
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt <= '0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    state <= (MUL_CYCLES == 2) ? DONE : BUSY;
                    cnt <= 5'(MUL_CYCLES - 2);
                end
                BUSY: begin
                    cnt <= cnt - 1'b1;
                    if (cnt <= 5'd1) state <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: rtl/hazard_sequencer.sv
// hazard_sequencer: forwarding selects, load-use/PC-write/multi-cycle stalls and flushes
// for the 5-stage F/D/E/M/W core.
module hazard_sequencer import hazard_pkg::*; #(
    parameter int MUL_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] RA1D,
    input  logic [3:0] RA2D,
    input  logic [3:0] RA1E,
    input  logic [3:0] RA2E,
    input  logic [3:0] WA3E,
    input  logic [3:0] WA3M,
    input  logic [3:0] WA3W,
    input  logic       RegWriteE,
    input  logic       RegWriteM,
    input  logic       RegWriteW,
    input  logic       MemtoRegE,
    input  logic       PCSrcD,
    input  logic       BranchTakenE,
    input  logic       MulStartE,
    output logic [1:0] forwardAE,
    output logic [1:0] forwardBE,
    output logic       StallF,
    output logic       StallD,
    output logic       StallE,
    output logic       FlushD,
    output logic       FlushE,
    output logic       MulBusy,
    output logic       MulDone
);
    fwd_sel_t fwdA, fwdB;
    logic pendE, pendM, pendW, ldrStall, pcWrPendingF;
    mc_sequencer #(.MUL_CYCLES(MUL_CYCLES)) mcSeq (
        .clk(clk), .reset(reset), .start(MulStartE), .kill(BranchTakenE),
        .busy(MulBusy), .done(MulDone)
    );
    assign fwdA = reset ? FWD_REG : fwdSel(RA1E, WA3M, WA3W, RegWriteM, RegWriteW);
    assign fwdB = reset ? FWD_REG : fwdSel(RA2E, WA3M, WA3W, RegWriteM, RegWriteW);
    assign forwardAE = fwdA;
    assign forwardBE = fwdB;
    assign ldrStall = MemtoRegE && RegWriteE && (RA1D == WA3E || RA2D == WA3E);
    assign pcWrPendingF = PCSrcD || pendE || pendM;
    assign StallF = !reset && (ldrStall || pcWrPendingF || MulBusy);
    assign StallD = !reset && (ldrStall || MulBusy);
    assign StallE = MulBusy;
    assign FlushD = reset || (!MulBusy && (pcWrPendingF || pendW || BranchTakenE));
    assign FlushE = reset || (!MulBusy && (ldrStall || BranchTakenE));
    // Tracks a PC-writing instruction as it travels E -> M -> W
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pendE <= 1'b0;
            pendM <= 1'b0;
            pendW <= 1'b0;
        end else begin
            pendM <= pendE;
            pendW <= pendM;
            pendE <= FlushE ? 1'b0 : StallE ? pendE : PCSrcD;
        end
    end
endmodule
